// File: rtl/fas.sv
// fas: registered ripple adder/subtractor built from identical bit cells; FAS_OVERFLOW_EN adds a signed-overflow flag.
// Latency 1 cycle, no backpressure: a new operation is accepted every clock.

module fas_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  input  logic a_ns,
  output logic s,
  output logic co
);

  logic axb;

  assign axb = a ^ b;
  assign s   = axb ^ ci;
  // Add propagates carry on a^b; subtract propagates borrow on a==b.
  assign co  = a_ns ? ((a & b) | (ci & axb))
                    : ((~a & b) | (ci & ~axb));

endmodule

module fas #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             a_ns,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef FAS_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("fas: WIDTH must be in 1..64");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_nxt;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fas_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .ci   (c[i]),
      .a_ns (a_ns),
      .s    (s_nxt[i]),
      .co   (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= s_nxt;
      cout <= c[WIDTH];
    end
  end

`ifdef FAS_OVERFLOW_EN
  // For WIDTH=1 the carry into the MSB is cin itself.
  logic ovf_nxt;

  assign ovf_nxt = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fas.sv
// Bench for fas: WIDTH=1 and WIDTH=8 instances checked against an arithmetic reference model.
module tb_fas;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       a1, b1, cin1, ns1;
  logic       s1, cout1;
  logic [7:0] a8, b8;
  logic       cin8, ns8;
  logic [7:0] s8;
  logic       cout8;
  logic       ovf1, ovf8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fas #(.WIDTH(1)) u_fas1 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .a_ns (ns1),
    .s    (s1),
    .cout (cout1)
`ifdef FAS_OVERFLOW_EN
    ,
    .ovf  (ovf1)
`endif
  );

  fas #(.WIDTH(8)) u_fas8 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .a_ns (ns8),
    .s    (s8),
    .cout (cout8)
`ifdef FAS_OVERFLOW_EN
    ,
    .ovf  (ovf8)
`endif
  );

`ifndef FAS_OVERFLOW_EN
  assign ovf1 = 1'b0;
  assign ovf8 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic void model(input int w, input int a, input int b, input int ci, input int add,
                                output int s, output int co, output int ov);
    int m, sa, sb, full, r;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (add != 0) begin
      full = a + b + ci;
      s    = full % m;
      co   = (full >= m) ? 1 : 0;
      r    = sa + sb + ci;
    end else begin
      full = a - b - ci;
      s    = (full + 2 * m) % m;
      co   = (a < b + ci) ? 1 : 0;
      r    = sa - sb - ci;
    end
    ov = (r > m / 2 - 1 || r < -(m / 2)) ? 1 : 0;
  endfunction

  task automatic step(input string tag,
                      input logic x_a1, input logic x_b1, input logic x_c1, input logic x_n1,
                      input logic [7:0] x_a8, input logic [7:0] x_b8, input logic x_c8, input logic x_n8);
    int es1, ec1, eo1, es8, ec8, eo8;
    a1 = x_a1; b1 = x_b1; cin1 = x_c1; ns1 = x_n1;
    a8 = x_a8; b8 = x_b8; cin8 = x_c8; ns8 = x_n8;
    model(1, int'(x_a1), int'(x_b1), int'(x_c1), int'(x_n1), es1, ec1, eo1);
    model(8, int'(x_a8), int'(x_b8), int'(x_c8), int'(x_n8), es8, ec8, eo8);
    @(posedge clk);
    #1;
    chk({tag, ".s1"}, 64'(s1), 64'(es1));
    chk({tag, ".cout1"}, 64'(cout1), 64'(ec1));
    chk({tag, ".s8"}, 64'(s8), 64'(es8));
    chk({tag, ".cout8"}, 64'(cout8), 64'(ec8));
`ifdef FAS_OVERFLOW_EN
    chk({tag, ".ovf1"}, 64'(ovf1), 64'(eo1));
    chk({tag, ".ovf8"}, 64'(ovf8), 64'(eo8));
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".s1"}, 64'(s1), 64'd0);
    chk({tag, ".cout1"}, 64'(cout1), 64'd0);
    chk({tag, ".s8"}, 64'(s8), 64'd0);
    chk({tag, ".cout8"}, 64'(cout8), 64'd0);
`ifdef FAS_OVERFLOW_EN
    chk({tag, ".ovf1"}, 64'(ovf1), 64'd0);
    chk({tag, ".ovf8"}, 64'(ovf8), 64'd0);
`endif
  endtask

  initial begin
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; ns1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; ns8 = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    repeat (3) begin
      @(posedge clk);
      #1 chk_zero("rst_hold");
    end
    rst_n = 1'b1;
    #2 chk_zero("rst_release_pre_edge");

    // Directed cases; first step shows the first post-reset capture.
    step("first_add",  1, 1, 0, 1, 8'hFF, 8'h01, 0, 1);
    step("sub_0m1",    0, 1, 0, 0, 8'h05, 8'h07, 0, 0);
    step("sub_eq",     1, 1, 0, 0, 8'h80, 8'h01, 0, 0);
    step("add_01",     0, 1, 0, 1, 8'h3C, 8'h3C, 0, 0);
    step("add_111",    1, 1, 1, 1, 8'hFF, 8'hFF, 1, 1);
    step("sub_00b",    0, 0, 1, 0, 8'h00, 8'h00, 1, 0);
    step("ovf_add",    0, 0, 1, 1, 8'h7F, 8'h01, 0, 1);
    step("ovf_sub",    1, 0, 1, 0, 8'h7F, 8'hFF, 0, 0);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      step("exh", v[3], v[2], v[1], v[0],
           8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset between edges while the result is non-zero.
    step("pre_mid_rst", 1, 0, 0, 1, 8'h55, 8'h22, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst_async");
    @(posedge clk);
    #1 chk_zero("mid_rst_hold");
    rst_n = 1'b1;
    step("post_rst", 0, 1, 1, 1, 8'h10, 8'h20, 1, 0);
    step("post_rst2", 1, 0, 1, 0, 8'hA5, 8'h5A, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
